// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one variable-latency memory between instruction fetch and data ports
module unified_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall_i,
  output logic          stall_d,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  state_t state;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic grant_d, done;
  logic [DW-1:0] resp_data;
  // data wins contention until it has starved fetch for MAX_D_STREAK grants
  assign grant_d = d_req & (~i_req | (streak != 4'(MAX_D_STREAK)));
  assign done = m_ready | (tcnt == 8'(TIMEOUT - 1));
  assign resp_data = m_ready ? m_rdata : '0;
  assign stall_i = i_req & ~i_valid;
  assign stall_d = d_req & ~d_valid;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      bus_err <= 1'b0;
      streak  <= '0;
      tcnt    <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_req) streak <= '0;
          if (grant_d) begin
            state   <= BUSY_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            tcnt    <= '0;
            if (i_req) streak <= streak + 4'd1;
          end else if (i_req) begin
            state  <= BUSY_I;
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= i_addr;
            tcnt   <= '0;
            streak <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state   <= RESP;
            m_req   <= 1'b0;
            bus_err <= ~m_ready;
            if (state == BUSY_I) begin
              i_rdata <= resp_data;
              i_valid <= 1'b1;
            end else begin
              d_rdata <= resp_data;
              d_valid <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench; stimulus pushes expected responses, a monitor checks each valid pulse
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic i_req, d_req, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic i_valid, d_valid, stall_i, stall_d, m_req, m_we, bus_err;

  typedef struct {
    bit          port_d;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int mem_wait = 0;
  bit spurious = 1'b0;
  int busy_cyc = 0;

  unified_mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_i(stall_i), .stall_d(stall_d),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: answers after mem_wait BUSY cycles (never when negative)
  always @(negedge clk) begin
    if (m_req) begin
      m_ready = (mem_wait >= 0) && (busy_cyc == mem_wait);
      m_rdata = m_ready ? mem_val(m_addr) : 32'h0;
      busy_cyc++;
    end else begin
      m_ready = spurious;
      m_rdata = spurious ? 32'hBAD0BAD0 : 32'h0;
      busy_cyc = 0;
    end
  end

  always @(negedge clk) begin
    if (reset && (i_valid || d_valid)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got i_valid=%0b d_valid=%0b expected no response", i_valid, d_valid);
      end else begin
        e = q.pop_front();
        chk("onehot_valid", 32'(i_valid & d_valid), 32'h0);
        chk("valid_port", 32'(d_valid), 32'(e.port_d));
        chk("rdata", d_valid ? d_rdata : i_rdata, e.data);
        chk("bus_err", 32'(bus_err), 32'(e.err));
      end
    end else if (reset && bus_err) begin
      chk("bus_err_alone", 32'(bus_err), 32'h0);
    end
  end

  task automatic wait_valid(input string name, input int exp_lat, input bit chk_m,
                            input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!i_valid && !d_valid) begin
        chk({name, "_stall_i"}, 32'(stall_i), 32'(i_req));
        chk({name, "_stall_d"}, 32'(stall_d), 32'(d_req));
        if (chk_m && m_req) begin
          chk({name, "_m_addr"}, m_addr, addr);
          chk({name, "_m_we"}, 32'(m_we), 32'(we));
          if (we) chk({name, "_m_wdata"}, m_wdata, wdata);
        end
      end else begin
        chk({name, "_stall_done"}, 32'(d_valid ? stall_d : stall_i), 32'h0);
        chk({name, "_m_req_dropped"}, 32'(m_req), 32'h0);
      end
    end while (!(i_valid || d_valid) && n < 40);
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int n, got;
    reset = 1'b0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    chk("rst_valids", 32'({i_valid, d_valid, bus_err}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single load, ready on 3rd BUSY cycle
    mem_wait = 2;
    q.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    d_req = 1; d_we = 0; d_addr = 32'h100;
    wait_valid("load", 4, 1'b1, 1'b0, 32'h100, 32'h0);
    d_req = 0;
    repeat (2) @(negedge clk);

    // store
    mem_wait = 1;
    q.push_back('{1'b1, mem_val(32'h20), 1'b0});
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    wait_valid("store", 3, 1'b1, 1'b1, 32'h20, 32'h12345678);
    d_req = 0; d_we = 0;
    repeat (2) @(negedge clk);

    // fetch timeout: memory never answers
    mem_wait = -1;
    q.push_back('{1'b0, 32'h0, 1'b1});
    i_req = 1; i_addr = 32'h0;
    wait_valid("timeout", 9, 1'b1, 1'b0, 32'h0, 32'h0);
    i_req = 0;
    repeat (2) @(negedge clk);

    // spurious ready while idle
    mem_wait = 0;
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spurious_m_req", 32'(m_req), 0);
    end
    spurious = 1'b0;
    @(negedge clk);
    q.push_back('{1'b0, mem_val(32'h80), 1'b0});
    i_req = 1; i_addr = 32'h80;
    wait_valid("post_spurious", 2, 1'b1, 1'b0, 32'h80, 32'h0);
    i_req = 0;
    repeat (2) @(negedge clk);

    // contention: expect D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      if (k == 4) q.push_back('{1'b0, mem_val(32'h4000), 1'b0});
      else if (k == 9) q.push_back('{1'b0, mem_val(32'h4004), 1'b0});
      else q.push_back('{1'b1, mem_val(32'h1000 + 32'(4 * (k < 4 ? k : k - 1))), 1'b0});
    end
    i_req = 1; i_addr = 32'h4000;
    d_req = 1; d_addr = 32'h1000; d_we = 0;
    n = 0; got = 0;
    while (got < 10 && n < 100) begin
      @(negedge clk);
      n++;
      if (d_valid) begin d_addr = d_addr + 4; got++; end
      if (i_valid) begin i_addr = i_addr + 4; got++; end
    end
    i_req = 0; d_req = 0;
    chk("contention_count", 32'(got), 10);
    chk("contention_cycles", 32'(n), 29);
    repeat (2) @(negedge clk);

    // reset during BUSY_D discards the load; fetch afterwards is normal
    mem_wait = 10;
    d_req = 1; d_addr = 32'h300;
    repeat (2) @(negedge clk);
    chk("pre_reset_m_req", 32'(m_req), 1);
    reset = 1'b0;
    #1;
    chk("async_reset_m_req", 32'(m_req), 0);
    @(negedge clk);
    d_req = 0; i_req = 1; i_addr = 32'h44; mem_wait = 0;
    @(negedge clk);
    chk("reset_no_valid", 32'({i_valid, d_valid}), 0);
    q.push_back('{1'b0, mem_val(32'h44), 1'b0});
    reset = 1'b1;
    wait_valid("after_reset", 2, 1'b1, 1'b0, 32'h44, 32'h0);
    i_req = 0;
    repeat (4) @(negedge clk);

    chk("pending_responses", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
